// File: rtl/cpu_pkg.sv
// Shared execute-stage types and sizing helpers for the multiply/divide unit.
package cpu_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'd0,
      MDU_MULTU = 2'd1,
      MDU_DIV   = 2'd2,
      MDU_DIVU  = 2'd3
   } mdu_op_t;

   localparam int unsigned MDU_MUL_LAT_MAX = 8;
   localparam int unsigned MDU_MUL_CNT_W   = $clog2(MDU_MUL_LAT_MAX + 1);

   // Width of a counter that must hold the values 0..width inclusive.
   function automatic int unsigned mdu_iter_cnt_w(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Radix-2 restoring divider datapath: magnitude conversion on load, one quotient
// bit per cycle (the first bit is produced by the load cycle itself), sign fix on output.
module mdu_div_iter
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             run,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last_c,
   output logic [WIDTH-1:0] quo_c,
   output logic [WIDTH-1:0] rem_c
);

   localparam int unsigned CNT_W = mdu_iter_cnt_w(WIDTH);

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic [WIDTH-1:0] rem_in, quo_in, dvs_in;
   logic [WIDTH-1:0] rem_nx, quo_nx;
   logic [WIDTH:0]   rem_sh, diff;
   logic             neg_quo_q, neg_rem_q;
   logic [CNT_W-1:0] cnt_q;
   logic             step;

   always_comb begin
      a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
      b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
   end

   // One restoring step; on load it starts from a zero remainder and |a|.
   always_comb begin
      rem_in = load ? '0    : rem_q;
      quo_in = load ? a_mag : quo_q;
      dvs_in = load ? b_mag : dvs_q;
      rem_sh = {rem_in, quo_in[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvs_in};
      if (!diff[WIDTH]) begin
         rem_nx = diff[WIDTH-1:0];
         quo_nx = {quo_in[WIDTH-2:0], 1'b1};
      end else begin
         rem_nx = rem_sh[WIDTH-1:0];
         quo_nx = {quo_in[WIDTH-2:0], 1'b0};
      end
   end

   assign step = run && (cnt_q < CNT_W'(WIDTH));

   always_ff @(posedge clk) begin
      if (load) begin
         rem_q     <= rem_nx;
         quo_q     <= quo_nx;
         dvs_q     <= b_mag;
         neg_quo_q <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_rem_q <= signed_mode && a[WIDTH-1];
      end else if (step) begin
         rem_q <= rem_nx;
         quo_q <= quo_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)       cnt_q <= '0;
      else if (load) cnt_q <= CNT_W'(1);
      else if (step) cnt_q <= cnt_q + CNT_W'(1);
   end

   assign last_c = (cnt_q == CNT_W'(WIDTH));
   assign quo_c  = neg_quo_q ? -quo_q : quo_q;
   assign rem_c  = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/alu_mdu.sv
// Multi-cycle multiply/divide unit producing HI/LO with a start/busy/done
// handshake and flush; the multiplier and control FSM live here.
module alu_mdu
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  mdu_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   state_t                   state, state_n;
   logic                     done_n, dbz_n;
   logic [WIDTH-1:0]         hi_n, lo_n;
   logic                     accept, div_load;
   mdu_op_t                  op_q;
   logic [WIDTH-1:0]         a_q, b_q;
   logic [MDU_MUL_CNT_W-1:0] mul_cnt;

   logic                     mul_signed;
   logic [WIDTH-1:0]         ma, mb;
   logic [2*WIDTH-1:0]       ma_x, mb_x, prod;

   logic                     div_run, div_signed, div_last_c;
   logic [WIDTH-1:0]         div_quo_c, div_rem_c;

   // Single multiplier; fed straight from the ports while idle so MUL_LAT=1 works.
   always_comb begin
      if (state == ST_IDLE) begin
         ma         = a;
         mb         = b;
         mul_signed = (op == MDU_MULT);
      end else begin
         ma         = a_q;
         mb         = b_q;
         mul_signed = (op_q == MDU_MULT);
      end
      ma_x = mul_signed ? {{WIDTH{ma[WIDTH-1]}}, ma} : {{WIDTH{1'b0}}, ma};
      mb_x = mul_signed ? {{WIDTH{mb[WIDTH-1]}}, mb} : {{WIDTH{1'b0}}, mb};
      prod = ma_x * mb_x;
   end

   assign div_run    = (state == ST_DIV);
   assign div_signed = (op == MDU_DIV);

   mdu_div_iter #(.WIDTH(WIDTH)) u_div (
      .clk         (clk),
      .rst         (rst),
      .load        (div_load),
      .run         (div_run),
      .signed_mode (div_signed),
      .a           (a),
      .b           (b),
      .last_c      (div_last_c),
      .quo_c       (div_quo_c),
      .rem_c       (div_rem_c)
   );

   // Next state and next output values; flush always wins over completion.
   always_comb begin
      state_n  = state;
      done_n   = 1'b0;
      hi_n     = hi;
      lo_n     = lo;
      dbz_n    = div_by_zero;
      accept   = 1'b0;
      div_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !flush) begin
               accept = 1'b1;
               if (!op[1]) begin
                  if (MUL_LAT == 1) begin
                     done_n = 1'b1;
                     hi_n   = prod[2*WIDTH-1:WIDTH];
                     lo_n   = prod[WIDTH-1:0];
                     dbz_n  = 1'b0;
                  end else begin
                     state_n = ST_MUL;
                  end
               end else if (b == '0) begin
                  done_n = 1'b1;
                  hi_n   = a;
                  lo_n   = '1;
                  dbz_n  = 1'b1;
               end else begin
                  div_load = 1'b1;
                  state_n  = ST_DIV;
               end
            end
         end
         ST_MUL: begin
            if (flush) begin
               state_n = ST_IDLE;
            end else if (mul_cnt == MDU_MUL_CNT_W'(MUL_LAT - 1)) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
               hi_n    = prod[2*WIDTH-1:WIDTH];
               lo_n    = prod[WIDTH-1:0];
               dbz_n   = 1'b0;
            end
         end
         ST_DIV: begin
            if (flush) begin
               state_n = ST_IDLE;
            end else if (div_last_c) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
               hi_n    = div_rem_c;
               lo_n    = div_quo_c;
               dbz_n   = 1'b0;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_n;
         busy        <= (state_n != ST_IDLE);
         done        <= done_n;
         hi          <= hi_n;
         lo          <= lo_n;
         div_by_zero <= dbz_n;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_q <= op;
         a_q  <= a;
         b_q  <= b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                  mul_cnt <= '0;
      else if (accept)          mul_cnt <= MDU_MUL_CNT_W'(1);
      else if (state == ST_MUL) mul_cnt <= mul_cnt + MDU_MUL_CNT_W'(1);
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed handshake/flush/reset cases plus
// random operations compared against an arithmetic reference model.
module tb_alu_mdu;
   import cpu_pkg::*;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned MUL_LAT = 3;

   logic        clk, rst, start, flush;
   mdu_op_t     op;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;
   logic        exp_dbz = 1'b0;

   alu_mdu #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Reference results straight from the arithmetic definition of each op.
   task automatic model(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l, output logic z,
                        output int lat);
      longint      sp, sq, sr;
      logic [63:0] up;
      z   = 1'b0;
      lat = int'(WIDTH) + 1;
      h   = '0;
      l   = '0;
      case (o)
         MDU_MULT: begin
            sp  = longint'($signed(x)) * longint'($signed(y));
            up  = 64'(sp);
            h   = up[63:32];
            l   = up[31:0];
            lat = int'(MUL_LAT);
         end
         MDU_MULTU: begin
            up  = {32'd0, x} * {32'd0, y};
            h   = up[63:32];
            l   = up[31:0];
            lat = int'(MUL_LAT);
         end
         default: begin
            if (y == 32'd0) begin
               h   = x;
               l   = 32'hFFFF_FFFF;
               z   = 1'b1;
               lat = 1;
            end else if (o == MDU_DIVU) begin
               l = x / y;
               h = x % y;
            end else begin
               sp = longint'($signed(x));
               sq = sp / longint'($signed(y));
               sr = sp % longint'($signed(y));
               l  = 32'(sq);
               h  = 32'(sr);
            end
         end
      endcase
   endtask

   // Launch from the current cycle (cycle 0); returns in the done cycle.
   task automatic run_op(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] mh, ml;
      logic        mz;
      int          lat, cyc;
      model(o, x, y, mh, ml, mz, lat);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op = mdu_op_t'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      cyc = 1;
      if (lat > 1) check("busy_cycle1", 64'(busy), 64'(1));
      while (done !== 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", 64'(cyc), 64'(lat));
      check("busy_in_done", 64'(busy), 64'(0));
      check("hi", 64'(hi), 64'(mh));
      check("lo", 64'(lo), 64'(ml));
      check("div_by_zero", 64'(div_by_zero), 64'(mz));
      exp_hi = mh; exp_lo = ml; exp_dbz = mz;
   endtask

   initial begin
      mdu_op_t     ro;
      logic [31:0] rx, ry;
      int          sel;

      rst = 1'b1; start = 1'b0; flush = 1'b0; op = MDU_MULT; a = '0; b = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_hi", 64'(hi), 64'(0));
      check("rst_lo", 64'(lo), 64'(0));
      check("rst_dbz", 64'(div_by_zero), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed arithmetic, with a divide issued in the MULTU done cycle.
      run_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3);
      run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
      run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2);
      run_op(MDU_DIVU,  32'd7, 32'd2);
      run_op(MDU_DIVU,  32'd7, 32'd0);
      run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      @(posedge clk); #1;

      // Divide with an ignored start at cycle 5 and a flush at cycle 10.
      op = MDU_DIV; a = 32'd1000; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 10; c++) begin
         check("flushdiv_busy", 64'(busy), 64'(1));
         check("flushdiv_nodone", 64'(done), 64'(0));
         start = (c == 5);
         op    = MDU_MULT;
         a     = $urandom;
         b     = $urandom;
         flush = (c == 10);
         @(posedge clk); #1;
      end
      start = 1'b0; flush = 1'b0;
      check("flush_busy", 64'(busy), 64'(0));
      check("flush_done", 64'(done), 64'(0));
      check("flush_hi_hold", 64'(hi), 64'(exp_hi));
      check("flush_lo_hold", 64'(lo), 64'(exp_lo));
      run_op(MDU_DIVU, 32'd100, 32'd9);
      @(posedge clk); #1;

      // Flush on the final multiply cycle suppresses done and the update.
      op = MDU_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flushlast_done", 64'(done), 64'(0));
      check("flushlast_busy", 64'(busy), 64'(0));
      check("flushlast_hi", 64'(hi), 64'(exp_hi));
      check("flushlast_lo", 64'(lo), 64'(exp_lo));

      // Flush together with start in idle drops the start.
      op = MDU_MULT; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flushstart_busy", 64'(busy), 64'(0));
      for (int c = 0; c < 4; c++) begin
         check("flushstart_nodone", 64'(done), 64'(0));
         @(posedge clk); #1;
      end

      // Reset in the middle of a multiply.
      op = MDU_MULT; a = 32'd5; b = 32'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("rstmul_busy1", 64'(busy), 64'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstmul_busy", 64'(busy), 64'(0));
      check("rstmul_done", 64'(done), 64'(0));
      check("rstmul_hi", 64'(hi), 64'(0));
      check("rstmul_lo", 64'(lo), 64'(0));
      exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
      for (int c = 0; c < 5; c++) begin
         check("rstmul_nodone", 64'(done), 64'(0));
         @(posedge clk); #1;
      end

      // Reset in the middle of a divide.
      op = MDU_DIV; a = 32'hFFFF_0000; b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstdiv_busy", 64'(busy), 64'(0));
      for (int c = 0; c < 40; c++) begin
         check("rstdiv_nodone", 64'(done), 64'(0));
         @(posedge clk); #1;
      end

      // Random operations, some back-to-back, with special operand corners.
      for (int i = 0; i < 24; i++) begin
         ro  = mdu_op_t'($urandom_range(0, 3));
         rx  = $urandom;
         ry  = $urandom;
         sel = int'($urandom_range(0, 7));
         if (sel == 0) ry = 32'd0;
         if (sel == 1) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
         if (sel == 2) ry = 32'(int'($urandom_range(1, 5)) - 3);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            check("gap_nodone", 64'(done), 64'(0));
         end
         run_op(ro, rx, ry);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
